// File: rtl/spi_bus_arbiter.sv
// Round-robin arbiter sharing one 3-wire SPI bus among NUM_REQ masters, with a
// fixed idle gap between grants and a per-grant timeout that masks stuck masters.
module spi_bus_arbiter #(
  parameter int          NUM_REQ        = 4,
  parameter int          GAP_CYCLES     = 4,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd5_000_000,
  localparam int         ID_W           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk_50m,
  input  logic               locked,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  input  logic [NUM_REQ-1:0] m_spi_ce,
  input  logic [NUM_REQ-1:0] m_spi_sclk,
  input  logic [NUM_REQ-1:0] m_spi_dir,
  input  logic [NUM_REQ-1:0] m_spi_out,
  output logic               m_spi_in,
  output logic               spi_clk,
  inout  wire                spi_io,
  output logic [NUM_REQ-1:0] dev_ce,
  output logic               busy,
  output logic [ID_W-1:0]    active_id,
  output logic               timeout_err,
  output logic [ID_W-1:0]    err_id
);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    GAP
  } state_t;

  localparam logic [23:0]   TMO_LAST = TIMEOUT_CYCLES - 24'd1;
  localparam logic [7:0]    GAP_LAST = 8'(GAP_CYCLES - 1);
  localparam logic [ID_W:0] NREQ_W   = (ID_W + 1)'(NUM_REQ);
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

  state_t             state;
  state_t             state_next;
  logic [ID_W-1:0]    ptr;
  logic [ID_W-1:0]    winner;
  logic [NUM_REQ-1:0] winner_oh;
  logic               win_found;
  logic [ID_W:0]      cand;
  logic [NUM_REQ-1:0] mask;
  logic [NUM_REQ-1:0] eligible;
  logic [23:0]        tmo_cnt;
  logic [7:0]         gap_cnt;
  logic               req_held;
  logic               tmo_hit;
  logic               tmo_fire;
  logic               gap_done;
  logic               io_drive;
  logic               io_val;

  assign eligible = req & ~mask;
  assign req_held = req[active_id];
  assign tmo_hit  = (tmo_cnt == TMO_LAST);
  // A release in the same cycle as the timeout is a normal release, not an error.
  assign tmo_fire = (state == GRANT) && req_held && tmo_hit;
  assign gap_done = (gap_cnt == GAP_LAST);

  // First eligible master searching upward from ptr, wrapping modulo NUM_REQ.
  always_comb begin
    winner    = '0;
    winner_oh = '0;
    win_found = 1'b0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr} + (ID_W + 1)'(k);
      if (cand >= NREQ_W) cand = cand - NREQ_W;
      if (!win_found && eligible[cand[ID_W-1:0]]) begin
        winner                      = cand[ID_W-1:0];
        winner_oh                   = '0;
        winner_oh[cand[ID_W-1:0]]   = 1'b1;
        win_found                   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_50m) begin
    if (!locked) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (win_found) state_next = GRANT;
      GRANT:   if (!req_held || tmo_hit) state_next = GAP;
      GAP:     if (gap_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_50m) begin
    if (!locked) begin
      grant       <= '0;
      active_id   <= '0;
      ptr         <= '0;
      mask        <= '0;
      tmo_cnt     <= '0;
      gap_cnt     <= '0;
      timeout_err <= 1'b0;
      err_id      <= '0;
    end else begin
      // grant is one-hot on the active master, so it doubles as the mask bit to set.
      mask <= (mask & req) | (tmo_fire ? grant : '0);
      case (state)
        IDLE: begin
          if (win_found) begin
            grant     <= winner_oh;
            active_id <= winner;
            ptr       <= (winner == LAST_ID) ? '0 : winner + ID_W'(1);
            tmo_cnt   <= '0;
          end
        end
        GRANT: begin
          if (!req_held || tmo_hit) begin
            grant     <= '0;
            active_id <= '0;
            gap_cnt   <= '0;
            if (tmo_fire) begin
              timeout_err <= 1'b1;
              err_id      <= active_id;
            end
          end else begin
            tmo_cnt <= tmo_cnt + 24'd1;
          end
        end
        GAP:     gap_cnt <= gap_cnt + 8'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    spi_clk  = 1'b0;
    dev_ce   = '1;
    io_drive = 1'b0;
    io_val   = 1'b0;
    if (state == GRANT) begin
      spi_clk           = m_spi_sclk[active_id];
      dev_ce[active_id] = m_spi_ce[active_id];
      io_drive          = ~m_spi_dir[active_id];
      io_val            = m_spi_out[active_id];
    end
  end

  assign busy     = (state != IDLE);
  assign spi_io   = io_drive ? io_val : 1'bz;
  assign m_spi_in = spi_io;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Self-checking bench for spi_bus_arbiter: directed scenarios plus randomized
// traffic, all checked each cycle against a behavioural arbitration model.
module tb_spi_bus_arbiter;

  localparam int N   = 4;
  localparam int GAP = 4;
  localparam int TMO = 16;

  logic         clk;
  logic         locked;
  logic [N-1:0] req;
  logic [N-1:0] grant;
  logic [N-1:0] m_spi_ce;
  logic [N-1:0] m_spi_sclk;
  logic [N-1:0] m_spi_dir;
  logic [N-1:0] m_spi_out;
  logic         m_spi_in;
  logic         spi_clk;
  wire          spi_io;
  logic [N-1:0] dev_ce;
  logic         busy;
  logic [1:0]   active_id;
  logic         timeout_err;
  logic [1:0]   err_id;
  logic         ext_en;
  logic         ext_val;

  int total = 0;
  int bad   = 0;
  bit cmp_en = 0;

  assign spi_io = ext_en ? ext_val : 1'bz;

  spi_bus_arbiter #(
    .NUM_REQ(N),
    .GAP_CYCLES(GAP),
    .TIMEOUT_CYCLES(24'd16)
  ) dut (
    .clk_50m(clk),
    .locked(locked),
    .req(req),
    .grant(grant),
    .m_spi_ce(m_spi_ce),
    .m_spi_sclk(m_spi_sclk),
    .m_spi_dir(m_spi_dir),
    .m_spi_out(m_spi_out),
    .m_spi_in(m_spi_in),
    .spi_clk(spi_clk),
    .spi_io(spi_io),
    .dev_ce(dev_ce),
    .busy(busy),
    .active_id(active_id),
    .timeout_err(timeout_err),
    .err_id(err_id)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: owner of the bus (-1 = none), its grant age, remaining gap
  // cycles, round-robin start point, masked masters and the sticky error.
  int     m_own = -1;
  int     m_age = 0;
  int     m_gap = 0;
  int     m_ptr = 0;
  bit [N-1:0] m_mask = '0;
  bit     m_err = 0;
  int     m_err_id = 0;

  always @(posedge clk) begin
    bit [N-1:0] nmask;
    if (!locked) begin
      m_own = -1; m_age = 0; m_gap = 0; m_ptr = 0;
      m_mask = '0; m_err = 0; m_err_id = 0;
    end else begin
      nmask = m_mask & req;
      if (m_own >= 0) begin
        if (!req[m_own]) begin
          m_own = -1;
          m_gap = GAP;
        end else if (m_age == TMO - 1) begin
          m_err = 1;
          m_err_id = m_own;
          nmask[m_own] = 1'b1;
          m_own = -1;
          m_gap = GAP;
        end else begin
          m_age++;
        end
      end else if (m_gap > 0) begin
        m_gap--;
      end else begin
        for (int k = 0; k < N; k++) begin
          int c;
          c = (m_ptr + k) % N;
          if (req[c] && !m_mask[c]) begin
            m_own = c;
            m_age = 0;
            m_ptr = (c + 1) % N;
            break;
          end
        end
      end
      m_mask = nmask;
    end
  end

  function automatic bit model_drives();
    return (m_own >= 0) && !m_spi_dir[m_own];
  endfunction

  always @(negedge clk) begin
    logic [N-1:0] eg;
    logic [N-1:0] ece;
    logic         esclk;
    if (cmp_en) begin
      eg = '0; ece = '1; esclk = 1'b0;
      if (m_own >= 0) begin
        eg[m_own]  = 1'b1;
        ece[m_own] = m_spi_ce[m_own];
        esclk      = m_spi_sclk[m_own];
      end
      check_output("grant", 32'(grant), 32'(eg));
      check_output("busy", 32'(busy), 32'((m_own >= 0) || (m_gap > 0)));
      check_output("active_id", 32'(active_id), (m_own >= 0) ? m_own : 0);
      check_output("timeout_err", 32'(timeout_err), 32'(m_err));
      check_output("err_id", 32'(err_id), m_err_id);
      check_output("spi_clk", 32'(spi_clk), 32'(esclk));
      check_output("dev_ce", 32'(dev_ce), 32'(ece));
      if (model_drives()) begin
        check_output("spi_io_drv", 32'(spi_io), 32'(m_spi_out[m_own]));
        check_output("m_spi_in_drv", 32'(m_spi_in), 32'(m_spi_out[m_own]));
      end else if (ext_en) begin
        check_output("m_spi_in_ext", 32'(m_spi_in), 32'(ext_val));
      end
      check_output("grant_onehot0", 32'($onehot0(grant)), 32'd1);
      check_output("dev_ce_one_low", 32'($countones(~dev_ce) <= 1), 32'd1);
    end
  end

  function automatic int oh_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    tick();
    locked = 1'b0; req = '0; ext_en = 1'b0;
    repeat (2) tick();
    locked = 1'b1;
  endtask

  int hold [N];

  task automatic apply_stimulus();
    for (int i = 0; i < N; i++) begin
      if (!req[i]) begin
        if ($urandom_range(7) == 0) begin
          req[i]  = 1'b1;
          hold[i] = int'($urandom_range(24, 1));
        end
      end else if (m_own == i) begin
        if (hold[i] == 0) req[i] = 1'b0;
        else hold[i]--;
      end else if (m_mask[i] && $urandom_range(3) == 0) begin
        req[i] = 1'b0;
      end else if ($urandom_range(63) == 0) begin
        req[i] = 1'b0;
      end
    end
    m_spi_sclk = 4'($urandom);
    m_spi_ce   = 4'($urandom);
    m_spi_dir  = 4'($urandom);
    m_spi_out  = 4'($urandom);
    ext_val    = 1'($urandom);
    ext_en     = !model_drives() && ($urandom_range(1) == 1);
    locked     = ($urandom_range(399) != 0);
  endtask

  initial begin
    int n;
    int gapc;
    int held;
    int found;
    int order[$];
    int exp_order[5] = '{0, 1, 2, 3, 0};

    locked = 1'b1; req = '0; ext_en = 1'b0; ext_val = 1'b0;
    m_spi_ce = '1; m_spi_sclk = '0; m_spi_dir = '1; m_spi_out = '0;

    // Reset state
    apply_reset();
    cmp_en = 1;
    @(negedge clk);
    check_output("rst_grant", 32'(grant), 32'h0);
    check_output("rst_busy", 32'(busy), 32'h0);
    check_output("rst_dev_ce", 32'(dev_ce), 32'hf);
    check_output("rst_spi_clk", 32'(spi_clk), 32'h0);

    // Single request, bus follows master 0, then release and gap
    tick();
    req = 4'b0001;
    tick();
    m_spi_sclk = 4'b0001; m_spi_ce = 4'b1110; m_spi_dir = 4'b0000; m_spi_out = 4'b0001;
    @(negedge clk);
    check_output("single_grant", 32'(grant), 32'h1);
    check_output("single_spi_clk", 32'(spi_clk), 32'h1);
    check_output("single_dev_ce", 32'(dev_ce), 32'he);
    check_output("single_spi_io", 32'(spi_io), 32'h1);
    tick();
    m_spi_dir = 4'b0001; ext_en = 1'b1; ext_val = 1'b0;
    @(negedge clk);
    check_output("dir_read_in", 32'(m_spi_in), 32'h0);
    tick();
    ext_en = 1'b0; req = 4'b0000;
    tick();
    @(negedge clk);
    check_output("release_grant", 32'(grant), 32'h0);
    n = busy ? 1 : 0;
    repeat (8) begin
      tick();
      @(negedge clk);
      if (busy) n++;
    end
    check_output("gap_busy_len", n, GAP);

    // Simultaneous requests, each holding ten grant cycles
    apply_reset();
    req = 4'b1111; held = 0; gapc = 0;
    for (int c = 0; c < 400 && order.size() < 5; c++) begin
      @(negedge clk);
      req = 4'b1111;
      if (grant != '0) begin
        if (held == 0) begin
          order.push_back(oh_idx(grant));
          if (order.size() > 1) check_output("rr_gap", gapc, GAP);
        end
        held++;
        if (held == 10) begin
          req[oh_idx(grant)] = 1'b0;
          held = 0;
          gapc = 0;
        end
      end else if (busy) begin
        gapc++;
      end
    end
    check_output("rr_count", order.size(), 5);
    for (int i = 0; i < 5 && i < order.size(); i++)
      check_output($sformatf("rr_order%0d", i), order[i], exp_order[i]);

    // Timeout on master 2, then masking until re-request
    apply_reset();
    req = 4'b0100; n = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (grant == 4'b0100) n++;
      else if (n > 0) break;
    end
    check_output("tmo_len", n, TMO);
    check_output("tmo_err", 32'(timeout_err), 32'h1);
    check_output("tmo_err_id", 32'(err_id), 32'h2);
    n = 0;
    repeat (30) begin
      @(negedge clk);
      if (grant[2]) n++;
    end
    check_output("tmo_masked", n, 0);
    tick(); req = 4'b0000;
    tick(); req = 4'b0100;
    found = 0;
    for (int c = 0; c < 20 && found == 0; c++) begin
      @(negedge clk);
      if (grant == 4'b0100) found = 1;
    end
    check_output("tmo_regrant", found, 1);

    // Reset during master 1 grant
    req = 4'b0010;
    found = 0;
    for (int c = 0; c < 40 && found == 0; c++) begin
      @(negedge clk);
      if (grant == 4'b0010) found = 1;
    end
    check_output("mid_grant_seen", found, 1);
    m_spi_sclk = 4'b1111; m_spi_ce = 4'b0000; m_spi_dir = 4'b1111;
    locked = 1'b0;
    @(negedge clk);
    check_output("mid_rst_dev_ce", 32'(dev_ce), 32'hf);
    check_output("mid_rst_spi_clk", 32'(spi_clk), 32'h0);
    check_output("mid_rst_grant", 32'(grant), 32'h0);
    check_output("mid_rst_err", 32'(timeout_err), 32'h0);
    locked = 1'b1; req = 4'b0110;
    @(negedge clk);
    check_output("post_rst_grant", 32'(grant), 32'h2);

    // Randomized traffic
    tick();
    req = '0;
    for (int i = 0; i < N; i++) hold[i] = 0;
    for (int c = 0; c < 4000; c++) begin
      tick();
      apply_stimulus();
    end
    tick();
    req = '0; ext_en = 1'b0; locked = 1'b1;
    repeat (10) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
